vape_ctrl: RTL and testbench



---
 rtl/vape_ctrl_pkg.sv | 40 ++++
 rtl/vape_ctrl_regs.sv | 107 ++++++++++
 rtl/vape_ctrl.sv | 145 ++++++++++++++
 tb/tb_vape_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vape_ctrl_pkg.sv
// Shared definitions for the VAPE configuration/lifecycle controller:
// FSM state encodings, failure cause codes, register offsets, CTRL/STATUS
// bit positions and the configuration validity rule.
package vape_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_BADCFG = 3'd1,
    CAUSE_VIOL   = 3'd2,
    CAUSE_ESCAPE = 3'd3,
    CAUSE_POST   = 3'd4
  } cause_e;

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_STATUS  = 3'd1;
  localparam logic [2:0] OFF_ER_MIN  = 3'd2;
  localparam logic [2:0] OFF_ER_MAX  = 3'd3;
  localparam logic [2:0] OFF_OR_MIN  = 3'd4;
  localparam logic [2:0] OFF_OR_MAX  = 3'd5;
  localparam logic [2:0] OFF_RUN_CYC = 3'd6;

  localparam int unsigned CTRL_ARM_BIT   = 0;
  localparam int unsigned CTRL_ABORT_BIT = 1;
  localparam int unsigned STAT_LOCK_BIT  = 7;

  // ER must be a non-empty, even-aligned range; OR must be non-empty.
  function automatic logic cfg_valid(input logic [15:0] er_min, input logic [15:0] er_max,
                                     input logic [15:0] or_min, input logic [15:0] or_max);
    return (er_min <= er_max) && (or_min <= or_max) && !er_min[0];
  endfunction

endpackage

// File: rtl/vape_ctrl_regs.sv
// Bus decode, region bound registers, lock check (with sticky lock_err)
// and combinational read mux for the VAPE controller register window.
module vape_ctrl_regs
  import vape_ctrl_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h0190,
  parameter logic [15:0] ER_MIN_RST = 16'hE000,
  parameter logic [15:0] ER_MAX_RST = 16'hE000,
  parameter logic [15:0] OR_MIN_RST = 16'h0200,
  parameter logic [15:0] OR_MAX_RST = 16'h0200
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [13:0] per_addr_i,
  input  logic [15:0] per_din_i,
  input  logic        per_en_i,
  input  logic [1:0]  per_we_i,
  output logic [15:0] per_dout_o,
  input  logic        locked_i,
  input  logic [2:0]  state_i,
  input  logic [2:0]  cause_i,
  input  logic        exec_flag_i,
  input  logic [15:0] run_cyc_i,
  output logic        arm_o,
  output logic        abort_o,
  output logic [15:0] er_min_o,
  output logic [15:0] er_max_o,
  output logic [15:0] or_min_o,
  output logic [15:0] or_max_o
);

  logic        sel, wr, cfg_wr;
  logic [2:0]  off;
  logic [15:0] er_min_q, er_min_d, er_max_q, er_max_d;
  logic [15:0] or_min_q, or_min_d, or_max_q, or_max_d;
  logic        lock_err_q, lock_err_d;

  assign sel     = per_en_i && (per_addr_i[13:3] == BASE_ADDR[14:4]);
  assign off     = per_addr_i[2:0];
  assign wr      = sel && (per_we_i == 2'b11);
  assign cfg_wr  = wr && (off >= OFF_ER_MIN) && (off <= OFF_OR_MAX);
  assign abort_o = wr && (off == OFF_CTRL) && per_din_i[CTRL_ABORT_BIT];
  assign arm_o   = wr && (off == OFF_CTRL) && per_din_i[CTRL_ARM_BIT] && !per_din_i[CTRL_ABORT_BIT];

  // Region register next-state: writes land only while unlocked.
  always_comb begin
    er_min_d = er_min_q;
    er_max_d = er_max_q;
    or_min_d = or_min_q;
    or_max_d = or_max_q;
    if (cfg_wr && !locked_i) begin
      case (off)
        OFF_ER_MIN: er_min_d = per_din_i;
        OFF_ER_MAX: er_max_d = per_din_i;
        OFF_OR_MIN: or_min_d = per_din_i;
        OFF_OR_MAX: or_max_d = per_din_i;
        default: ;
      endcase
    end
  end

  // Sticky lock error: write-1-to-clear, a same-cycle set wins.
  always_comb begin
    lock_err_d = lock_err_q;
    if (wr && (off == OFF_STATUS) && per_din_i[STAT_LOCK_BIT]) lock_err_d = 1'b0;
    if (cfg_wr && locked_i) lock_err_d = 1'b1;
  end

  // Register state with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      er_min_q   <= ER_MIN_RST;
      er_max_q   <= ER_MAX_RST;
      or_min_q   <= OR_MIN_RST;
      or_max_q   <= OR_MAX_RST;
      lock_err_q <= 1'b0;
    end else begin
      er_min_q   <= er_min_d;
      er_max_q   <= er_max_d;
      or_min_q   <= or_min_d;
      or_max_q   <= or_max_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Combinational read mux; zero when the window is not selected.
  always_comb begin
    per_dout_o = '0;
    if (sel) begin
      case (off)
        OFF_STATUS:  per_dout_o = {8'h00, lock_err_q, cause_i, exec_flag_i, state_i};
        OFF_ER_MIN:  per_dout_o = er_min_q;
        OFF_ER_MAX:  per_dout_o = er_max_q;
        OFF_OR_MIN:  per_dout_o = or_min_q;
        OFF_OR_MAX:  per_dout_o = or_max_q;
        OFF_RUN_CYC: per_dout_o = run_cyc_i;
        default:     per_dout_o = '0;
      endcase
    end
  end

  assign er_min_o = er_min_q;
  assign er_max_o = er_max_q;
  assign or_min_o = or_min_q;
  assign or_max_o = or_max_q;

endmodule

// File: rtl/vape_ctrl.sv
// VAPE monitor configuration and lifecycle controller (openMSP430 peripheral).
// Sequences arm -> entry at ER_min -> run -> exit at ER_max and latches the
// EXEC proof bit. Optional macro VAPE_CTRL_RUN_CYC_EN adds the RUN_CYC counter.
module vape_ctrl
  import vape_ctrl_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h0190,
  parameter logic [15:0] ER_MIN_RST = 16'hE000,
  parameter logic [15:0] ER_MAX_RST = 16'hE000,
  parameter logic [15:0] OR_MIN_RST = 16'h0200,
  parameter logic [15:0] OR_MAX_RST = 16'h0200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [15:0] pc,
  input  logic        exec,
  output logic [15:0] ER_min,
  output logic [15:0] ER_max,
  output logic [15:0] OR_min,
  output logic [15:0] OR_max,
  output logic        exec_flag,
  output logic        busy
);

  state_e      state_q, state_d;
  cause_e      cause_q, cause_d;
  logic        flag_q, flag_d;
  logic        arm, abort, locked;
  logic [15:0] run_cyc_q;

  assign locked = (state_q == ST_ARMED) || (state_q == ST_RUN);

  vape_ctrl_regs #(
    .BASE_ADDR (BASE_ADDR),
    .ER_MIN_RST(ER_MIN_RST),
    .ER_MAX_RST(ER_MAX_RST),
    .OR_MIN_RST(OR_MIN_RST),
    .OR_MAX_RST(OR_MAX_RST)
  ) u_regs (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .per_addr_i (per_addr),
    .per_din_i  (per_din),
    .per_en_i   (per_en),
    .per_we_i   (per_we),
    .per_dout_o (per_dout),
    .locked_i   (locked),
    .state_i    (state_q),
    .cause_i    (cause_q),
    .exec_flag_i(flag_q),
    .run_cyc_i  (run_cyc_q),
    .arm_o      (arm),
    .abort_o    (abort),
    .er_min_o   (ER_min),
    .er_max_o   (ER_max),
    .or_min_o   (OR_min),
    .or_max_o   (OR_max)
  );

  // Lifecycle next-state: bus ABORT/ARM override monitor-driven events.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    flag_d  = flag_q;
    if (abort) begin
      state_d = ST_IDLE;
      cause_d = CAUSE_NONE;
      flag_d  = 1'b0;
    end else if (arm && !locked) begin
      flag_d = 1'b0;
      if (cfg_valid(ER_min, ER_max, OR_min, OR_max)) begin
        state_d = ST_ARMED;
        cause_d = CAUSE_NONE;
      end else begin
        state_d = ST_FAIL;
        cause_d = CAUSE_BADCFG;
      end
    end else begin
      case (state_q)
        ST_ARMED: if (pc == ER_min) state_d = ST_RUN;
        ST_RUN: begin
          if (!exec) begin
            state_d = ST_FAIL;
            cause_d = CAUSE_VIOL;
          end else if (pc == ER_max) begin
            state_d = ST_DONE;
            flag_d  = 1'b1;
          end else if ((pc < ER_min) || (pc > ER_max)) begin
            state_d = ST_FAIL;
            cause_d = CAUSE_ESCAPE;
          end
        end
        ST_DONE: begin
          if (!exec) begin
            state_d = ST_FAIL;
            cause_d = CAUSE_POST;
            flag_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Lifecycle state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      flag_q  <= flag_d;
    end
  end

`ifdef VAPE_CTRL_RUN_CYC_EN
  logic [15:0] run_cyc_d;

  // Count RUN cycles; the entry edge loads zero and the count saturates.
  always_comb begin
    run_cyc_d = run_cyc_q;
    if ((state_q == ST_RUN) && (run_cyc_q != '1)) run_cyc_d = run_cyc_q + 16'd1;
    if ((state_d == ST_RUN) && (state_q != ST_RUN)) run_cyc_d = '0;
  end

  // RUN cycle counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_cyc_q <= '0;
    else          run_cyc_q <= run_cyc_d;
  end
`else
  assign run_cyc_q = '0;
`endif

  assign exec_flag = flag_q;
  assign busy      = locked;

endmodule

// File: tb/tb_vape_ctrl.sv
// Self-checking bench for vape_ctrl: directed stimulus, a behavioural model
// compared every cycle, and literal STATUS/register reads at key points.
module tb_vape_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic [15:0] per_dout;
  logic [15:0] pc = '0;
  logic        exec = 1'b0;
  logic [15:0] ER_min, ER_max, OR_min, OR_max;
  logic        exec_flag, busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  vape_ctrl #(
    .BASE_ADDR (15'h0190),
    .ER_MIN_RST(16'hE000),
    .ER_MAX_RST(16'hE000),
    .OR_MIN_RST(16'h0200),
    .OR_MAX_RST(16'h0200)
  ) dut (
    .clk(clk), .reset_n(reset_n), .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we), .per_dout(per_dout), .pc(pc), .exec(exec),
    .ER_min(ER_min), .ER_max(ER_max), .OR_min(OR_min), .OR_max(OR_max),
    .exec_flag(exec_flag), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // state: 0 idle, 1 armed, 2 run, 3 done, 4 fail. Registers kept by offset.
  logic [2:0]  m_state, m_cause;
  logic        m_flag, m_lock;
  logic [15:0] m_reg [0:7];
  logic [15:0] m_cyc;
  localparam logic [13:0] WIN = 14'h00C8;   // 0x0190 byte address as a word address

  task automatic m_reset();
    m_state = 0; m_cause = 0; m_flag = 0; m_lock = 0; m_cyc = 0;
    foreach (m_reg[i]) m_reg[i] = 16'h0000;
    m_reg[2] = 16'hE000; m_reg[3] = 16'hE000; m_reg[4] = 16'h0200; m_reg[5] = 16'h0200;
  endtask

  function automatic bit m_sel();
    return per_en && (per_addr >= WIN) && (per_addr <= WIN + 14'd7);
  endfunction

  function automatic logic [15:0] m_read(input int off);
    case (off)
      1: return {8'h00, m_lock, m_cause, m_flag, m_state};
      2, 3, 4, 5: return m_reg[off];
`ifdef VAPE_CTRL_RUN_CYC_EN
      6: return m_cyc;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_step();
    bit wr, armed_or_run;
    int off, prev;
    wr = m_sel() && (per_we == 2'b11);
    off = int'(per_addr - WIN);
    prev = m_state;
    armed_or_run = (prev == 1) || (prev == 2);
    if (wr && off == 1 && per_din[7]) m_lock = 0;
    if (wr && off >= 2 && off <= 5) begin
      if (armed_or_run) m_lock = 1;
      else m_reg[off] = per_din;
    end
    if (wr && off == 0 && per_din[1]) begin
      m_state = 0; m_cause = 0; m_flag = 0;
    end else if (wr && off == 0 && per_din[0] && !armed_or_run) begin
      m_flag = 0;
      if (m_reg[2] <= m_reg[3] && m_reg[4] <= m_reg[5] && m_reg[2] % 2 == 0) begin
        m_state = 1; m_cause = 0;
      end else begin
        m_state = 4; m_cause = 1;
      end
    end else if (prev == 1) begin
      if (pc == m_reg[2]) m_state = 2;
    end else if (prev == 2) begin
      if (!exec) begin m_state = 4; m_cause = 2; end
      else if (pc == m_reg[3]) begin m_state = 3; m_flag = 1; end
      else if (pc < m_reg[2] || pc > m_reg[3]) begin m_state = 4; m_cause = 3; end
    end else if (prev == 3) begin
      if (!exec) begin m_state = 4; m_cause = 4; m_flag = 0; end
    end
    if (prev == 2 && m_cyc != 16'hFFFF) m_cyc = m_cyc + 1;
    if (m_state == 2 && prev != 2) m_cyc = 0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_reset();
    else m_step();
  end

  // Compare every cycle, half a period after the active edge.
  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      chk("busy", {15'h0, busy}, {15'h0, (m_state == 1 || m_state == 2)});
      chk("exec_flag", {15'h0, exec_flag}, {15'h0, m_flag});
      chk("ER_min", ER_min, m_reg[2]);
      chk("ER_max", ER_max, m_reg[3]);
      chk("OR_min", OR_min, m_reg[4]);
      chk("OR_max", OR_max, m_reg[5]);
      chk("per_dout", per_dout, m_sel() ? m_read(int'(per_addr - WIN)) : 16'h0000);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input logic [15:0] p, input logic e);
    @(negedge clk); #1;
    per_en = 0; per_we = 2'b00; per_addr = '0; per_din = '0;
    pc = p; exec = e;
  endtask

  task automatic bus_wr(input int off, input logic [15:0] d, input logic [1:0] we = 2'b11);
    @(negedge clk); #1;
    per_en = 1; per_we = we; per_addr = WIN + 14'(off); per_din = d;
  endtask

  task automatic rd_expect(input string name, input int off, input logic [15:0] exp);
    @(negedge clk); #1;
    per_en = 1; per_we = 2'b00; per_addr = WIN + 14'(off); per_din = '0;
    #2 chk(name, per_dout, exp);
  endtask

  task automatic cfg(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    bus_wr(2, a); bus_wr(3, b); bus_wr(4, c); bus_wr(5, d);
  endtask

  task automatic run_to(input int first, input int last, input logic e);
    for (int a = first; a <= last; a += 2) tick(16'(a), e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    m_reset();
    #12 reset_n = 1'b1;
    chk_en = 1'b1;

    // reset values and unused offsets
    rd_expect("rst_status", 1, 16'h0000);
    rd_expect("rst_er_min", 2, 16'hE000);
    rd_expect("rst_or_max", 5, 16'h0200);
    rd_expect("ctrl_reads0", 0, 16'h0000);
    rd_expect("rsvd_reads0", 7, 16'h0000);
    rd_expect("runcyc_rst", 6, 16'h0000);

    // happy path with lock check while armed
    cfg(16'hE000, 16'hE0FE, 16'h0200, 16'h021F);
    bus_wr(2, 16'h1111, 2'b01);
    rd_expect("byte_wr_ignored", 2, 16'hE000);
    bus_wr(0, 16'h0001);
    bus_wr(2, 16'h1234);
    rd_expect("armed_lock", 1, 16'h0081);
    rd_expect("locked_er_min", 2, 16'hE000);
    bus_wr(1, 16'h0080);
    rd_expect("lock_cleared", 1, 16'h0001);
    bus_wr(0, 16'h0001);
    rd_expect("arm_in_armed_ignored", 1, 16'h0001);
    run_to('hE000, 'hE0FE, 1'b1);
    rd_expect("happy_done", 1, 16'h000B);
`ifdef VAPE_CTRL_RUN_CYC_EN
    rd_expect("run_cyc", 6, 16'd127);
`else
    rd_expect("run_cyc_off", 6, 16'h0000);
`endif
    tick(16'hE000, 1'b1);
    rd_expect("done_no_rearm", 1, 16'h000B);

    // post-exec tamper, then re-arm and re-run
    tick(16'hE000, 1'b0);
    rd_expect("post_fail", 1, 16'h0044);
    tick(16'hE000, 1'b1);
    bus_wr(0, 16'h0001);
    run_to('hE000, 'hE0FE, 1'b1);
    rd_expect("rerun_done", 1, 16'h000B);

    // bad configurations
    cfg(16'hE100, 16'hE000, 16'h0200, 16'h021F);
    bus_wr(0, 16'h0001);
    rd_expect("badcfg_order", 1, 16'h0014);
    cfg(16'hE001, 16'hE0FE, 16'h0200, 16'h021F);
    bus_wr(0, 16'h0001);
    rd_expect("badcfg_odd", 1, 16'h0014);
    bus_wr(0, 16'h0003);
    rd_expect("abort_wins", 1, 16'h0000);

    // violation at E020
    cfg(16'hE000, 16'hE0FE, 16'h0200, 16'h021F);
    bus_wr(0, 16'h0001);
    run_to('hE000, 'hE01E, 1'b1);
    tick(16'hE020, 1'b0);
    rd_expect("viol", 1, 16'h0024);

    // escape to C000
    bus_wr(0, 16'h0001);
    run_to('hE000, 'hE002, 1'b1);
    tick(16'hC000, 1'b1);
    rd_expect("escape", 1, 16'h0034);

    // exec low at ER_max: violation has priority over completion
    bus_wr(0, 16'h0001);
    tick(16'hE000, 1'b1);
    tick(16'hE0FE, 1'b0);
    rd_expect("viol_over_done", 1, 16'h0024);

    // abort from RUN
    bus_wr(0, 16'h0001);
    tick(16'hE000, 1'b1);
    tick(16'hE002, 1'b1);
    bus_wr(0, 16'h0002);
    rd_expect("abort_run", 1, 16'h0000);

    // asynchronous reset mid-RUN with a non-default ER_MIN
    cfg(16'hE010, 16'hE0FE, 16'h0200, 16'h021F);
    bus_wr(0, 16'h0001);
    tick(16'hE010, 1'b1);
    rd_expect("pre_rst_run", 1, 16'h0002);
    #1 chk("pre_rst_busy", {15'h0, busy}, 16'h0001);
    reset_n = 1'b0;
    #1;
    chk("rst_busy", {15'h0, busy}, 16'h0000);
    chk("rst_flag", {15'h0, exec_flag}, 16'h0000);
    chk("rst_ER_min", ER_min, 16'hE000);
    chk("rst_status_async", per_dout, 16'h0000);
    @(negedge clk); #1 reset_n = 1'b1;
    rd_expect("post_rst_er_min", 2, 16'hE000);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
